// File: rtl/exec_stage_ls_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : types (package)
//  Description : Shared definitions for the riscv-lite execute stage:
//                instruction and memory-control enums, the decoded
//                instruction bundle, register index type, well-known
//                register names and the execute FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package types;

  // The immediate travels at a fixed width and is sign-extended or
  // truncated to XLEN inside the stage, so the package stays XLEN-free.
  localparam int IMM_W     = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] regT;

  localparam regT X_zero = 5'd0;
  localparam regT X_ra   = 5'd1;

  typedef enum logic [3:0] {
    ADD   = 4'd0,
    ADDI  = 4'd1,
    AUIPC = 4'd2,
    LUI   = 4'd3,
    BLT   = 4'd4,
    JAL   = 4'd5,
    JALR  = 4'd6,
    LW    = 4'd7,
    SW    = 4'd8
  } instT;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } MemControlT;

  typedef struct packed {
    instT             inst;
    regT              rd;
    regT              rs1;
    regT              rs2;
    logic [IMM_W-1:0] imm;
  } decodedInstT;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } ExecStateT;

endpackage
`default_nettype wire

// File: rtl/exec_stage_ls_regfile_2r1w.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_2r1w
//  Description : Architectural register file, two combinational read ports,
//                one synchronous write port, x0 reads as zero.
//  Ports       : clk, rst        clock, async active-high reset (clears all)
//                i_ra1/i_ra2     read indices   -> o_rd1/o_rd2 read data
//                i_we/i_wa/i_wd  write enable, index, data
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_2r1w #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREGS)-1:0] i_ra1,
  input  logic [$clog2(NREGS)-1:0] i_ra2,
  output logic [XLEN-1:0]          o_rd1,
  output logic [XLEN-1:0]          o_rd2,
  input  logic                     i_we,
  input  logic [$clog2(NREGS)-1:0] i_wa,
  input  logic [XLEN-1:0]          i_wd
);

  logic [XLEN-1:0] r_regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == '0) ? '0 : r_regs[i_ra1];
  assign o_rd2 = (i_ra2 == '0) ? '0 : r_regs[i_ra2];

endmodule
`default_nettype wire

// File: rtl/exec_stage_ls.sv
`default_nettype none
// ============================================================================
//  Module      : exec_stage_ls
//  Description : Execute stage of the riscv-lite core. Integer subset plus
//                LW/SW, epoch-tagged fetch redirect, multi-cycle loads.
//  Ports       : clk, rst                      clock, async active-high reset
//                d, d_pc, d_epoch, d_valid     decoded instruction from decode
//                d_ready                       stage can accept this cycle
//                jump_valid/_pc/_epoch         registered fetch redirect
//                dmem_control/_addr/_writedata registered data-memory request
//                dmem_readdata/_valid          load response
//                retire_valid, retire_pc       architectural completion
//                err                           sticky illegal/misaligned flag
//  Revision    : 1.0  initial release
// ============================================================================
module exec_stage_ls
  import types::*;
#(
  parameter int          XLEN     = 32,
  parameter int          NREGS    = 32,
  parameter int          EPOCH_W  = 1,
  parameter logic [31:0] START_PC = 32'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  decodedInstT        d,
  input  logic [XLEN-1:0]    d_pc,
  input  logic [EPOCH_W-1:0] d_epoch,
  input  logic               d_valid,
  output logic               d_ready,
  output logic               jump_valid,
  output logic [XLEN-1:0]    jump_pc,
  output logic [EPOCH_W-1:0] jump_epoch,
  output MemControlT         dmem_control,
  output logic [XLEN-1:0]    dmem_addr,
  output logic [XLEN-1:0]    dmem_writedata,
  input  logic [XLEN-1:0]    dmem_readdata,
  input  logic               dmem_readdata_valid,
  output logic               retire_valid,
  output logic [XLEN-1:0]    retire_pc,
  output logic               err
);

  localparam int AW = $clog2(NREGS);

  ExecStateT          r_state, w_state_next;
  logic [EPOCH_W-1:0] r_epoch;
  logic               r_jump_valid, r_retire_valid, r_err;
  logic [XLEN-1:0]    r_jump_pc, r_retire_pc, r_dmem_addr, r_dmem_writedata;
  logic [EPOCH_W-1:0] r_jump_epoch;
  MemControlT         r_dmem_control;
  logic [AW-1:0]      r_load_rd;
  logic [XLEN-1:0]    r_load_pc;

  logic               w_accept, w_fresh, w_load_done;
  logic [XLEN-1:0]    w_imm, w_rs1v, w_rs2v, w_sum, w_pc4;
  logic               w_illegal, w_wb_en, w_jump, w_is_load, w_retire;
  logic [XLEN-1:0]    w_wb_data, w_target;
  MemControlT         w_mem;
  logic               w_rf_we;
  logic [AW-1:0]      w_rf_wa;
  logic [XLEN-1:0]    w_rf_wd;
  logic [EPOCH_W-1:0] w_next_epoch;

  // Acceptance is gated only by the FSM being idle; a stale-epoch
  // instruction is still consumed but w_fresh masks all of its effects.
  assign d_ready     = (r_state == IDLE);
  assign w_accept    = d_valid && d_ready;
  assign w_fresh     = w_accept && (d_epoch == r_epoch);
  assign w_load_done = (r_state == LOAD_WAIT) && dmem_readdata_valid;

  assign w_imm        = XLEN'(signed'(d.imm));
  assign w_sum        = w_rs1v + w_imm;
  assign w_pc4        = d_pc + XLEN'(4);
  assign w_next_epoch = r_epoch + EPOCH_W'(1);

  regfile_2r1w #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (d.rs1[AW-1:0]),
    .i_ra2 (d.rs2[AW-1:0]),
    .o_rd1 (w_rs1v),
    .o_rd2 (w_rs2v),
    .i_we  (w_rf_we),
    .i_wa  (w_rf_wa),
    .i_wd  (w_rf_wd)
  );

  // Instruction decode into effects; everything here is qualified by
  // w_fresh before it reaches state.
  always_comb begin
    w_illegal = 1'b0;
    w_wb_en   = 1'b0;
    w_wb_data = '0;
    w_jump    = 1'b0;
    w_target  = '0;
    w_mem     = MEM_NONE;
    w_is_load = 1'b0;
    case (d.inst)
      ADD:   begin w_wb_en = 1'b1; w_wb_data = w_rs1v + w_rs2v; end
      ADDI:  begin w_wb_en = 1'b1; w_wb_data = w_sum; end
      AUIPC: begin w_wb_en = 1'b1; w_wb_data = d_pc + w_imm; end
      LUI:   begin w_wb_en = 1'b1; w_wb_data = w_imm; end
      BLT: begin
        if ($signed(w_rs1v) < $signed(w_rs2v)) begin
          w_jump   = 1'b1;
          w_target = d_pc + w_imm;
        end
      end
      JAL: begin
        w_wb_en = 1'b1; w_wb_data = w_pc4;
        w_jump  = 1'b1; w_target  = d_pc + w_imm;
      end
      JALR: begin
        w_wb_en = 1'b1; w_wb_data = w_pc4;
        w_jump  = 1'b1; w_target  = w_sum & ~XLEN'(1);
      end
      LW: begin
        if (w_sum[1:0] != 2'b00) w_illegal = 1'b1;
        else begin w_mem = MEM_READ; w_is_load = 1'b1; end
      end
      SW: begin
        if (w_sum[1:0] != 2'b00) w_illegal = 1'b1;
        else w_mem = MEM_WRITE;
      end
      default: w_illegal = 1'b1;
    endcase
    w_retire = !w_illegal && !w_is_load;
  end

  // Load writeback and accept writeback never coincide: nothing is
  // accepted while in LOAD_WAIT.
  assign w_rf_we = (w_fresh && w_wb_en) || w_load_done;
  assign w_rf_wa = w_load_done ? r_load_rd : d.rd[AW-1:0];
  assign w_rf_wd = w_load_done ? dmem_readdata : w_wb_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:      if (w_fresh && w_is_load) w_state_next = LOAD_WAIT;
      LOAD_WAIT: if (dmem_readdata_valid)  w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_epoch          <= '0;
      r_jump_valid     <= 1'b0;
      r_jump_pc        <= '0;
      r_jump_epoch     <= '0;
      r_dmem_control   <= MEM_NONE;
      r_dmem_addr      <= '0;
      r_dmem_writedata <= '0;
      r_retire_valid   <= 1'b0;
      r_retire_pc      <= '0;
      r_err            <= 1'b0;
      r_load_rd        <= '0;
      r_load_pc        <= '0;
    end else begin
      r_jump_valid   <= w_fresh && w_jump;
      r_retire_valid <= (w_fresh && w_retire) || w_load_done;
      r_dmem_control <= w_fresh ? w_mem : MEM_NONE;
      if (w_fresh && w_jump) begin
        r_epoch      <= w_next_epoch;
        r_jump_epoch <= w_next_epoch;
        r_jump_pc    <= w_target;
      end
      if (w_fresh && (w_mem != MEM_NONE)) begin
        r_dmem_addr <= w_sum;
        if (w_mem == MEM_WRITE) r_dmem_writedata <= w_rs2v;
      end
      if (w_fresh && w_retire) r_retire_pc <= d_pc;
      else if (w_load_done)    r_retire_pc <= r_load_pc;
      if (w_fresh && w_is_load) begin
        r_load_rd <= d.rd[AW-1:0];
        r_load_pc <= d_pc;
      end
      if (w_fresh && w_illegal) r_err <= 1'b1;
    end
  end

  assign jump_valid     = r_jump_valid;
  assign jump_pc        = r_jump_pc;
  assign jump_epoch     = r_jump_epoch;
  assign dmem_control   = r_dmem_control;
  assign dmem_addr      = r_dmem_addr;
  assign dmem_writedata = r_dmem_writedata;
  assign retire_valid   = r_retire_valid;
  assign retire_pc      = r_retire_pc;
  assign err            = r_err;

endmodule
`default_nettype wire
